rsa_decrypt: RTL and testbench

RSA_DECRYPT -- requirements
Module: rsa_decrypt

---
 rtl/rsa_pkg.sv | 25 ++
 rtl/rsa_modmul.sv | 90 +++++++++
 rtl/rsa_decrypt.sv | 152 +++++++++++++++
 tb/tb_rsa_decrypt.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA definitions: default operand width, FSM state type and the
// modular-multiplier control word used by both the decrypt and encrypt sides.
package rsa_pkg;

  localparam int unsigned RsaWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSqr,
    StMul,
    StDone
  } rsa_state_e;

  typedef enum logic {
    MmOpSqr,
    MmOpMul
  } rsa_mm_op_e;

  typedef struct packed {
    logic       start;
    rsa_mm_op_e op;
  } rsa_mm_ctrl_t;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier, r = a*b mod n, MSB of b first.
// Takes exactly WIDTH cycles: the first iteration runs on the cycle start is
// seen (using the live operands), the remaining WIDTH-1 on latched copies.
// done and r are valid in the cycle whose closing edge completes the product.
// Operands a and b must already be reduced (< n).
module rsa_modmul import rsa_pkg::*; #(
  parameter int unsigned WIDTH = RsaWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_q, busy_d;
  logic [IdxW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;

  logic [WIDTH-1:0] cur_a, cur_b, cur_n, cur_r;
  logic [IdxW-1:0]  idx;
  logic             active;
  logic [WIDTH:0]   t0, t1;

  // One shift-add-reduce step; WIDTH+1 bits hold 2r and r+a without overflow
  always_comb begin
    cur_a  = busy_q ? a_q : a;
    cur_b  = busy_q ? b_q : b;
    cur_n  = busy_q ? n_q : n;
    cur_r  = busy_q ? r_q : '0;
    idx    = busy_q ? cnt_q : IdxW'(WIDTH - 1);
    active = busy_q | start;
    t0 = {cur_r, 1'b0};
    if (t0 >= {1'b0, cur_n}) t0 = t0 - {1'b0, cur_n};
    t1 = t0;
    if (cur_b[idx]) t1 = t0 + {1'b0, cur_a};
    if (t1 >= {1'b0, cur_n}) t1 = t1 - {1'b0, cur_n};
  end

  assign r    = t1[WIDTH-1:0];
  assign done = active && (idx == '0);

  // Next-state: latch operands on start, advance bit index each active cycle
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    r_d    = r_q;
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    if (active) begin
      r_d    = t1[WIDTH-1:0];
      cnt_d  = idx - IdxW'(1);
      busy_d = (idx != '0);
      if (!busy_q) begin
        a_d = a;
        b_d = b;
        n_d = n;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      r_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
    end
  end

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption M = C^d mod n by left-to-right square-and-always-multiply.
// Every exponent bit costs one square and one multiply, so latency is fixed
// regardless of d. decrypt_done is registered off the DONE state, which is
// what places it one edge after the final multiply (and 2 edges after capture
// on the operand-error path).
module rsa_decrypt import rsa_pkg::*; #(
  parameter int unsigned WIDTH = RsaWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             compute,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] M,
  output logic             decrypt_done,
  output logic             err
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] ct_q, ct_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  rsa_mm_ctrl_t     mm_ctrl;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_r;
  logic             mm_done;
  logic             operand_err;

  assign operand_err = (mod_q < WIDTH'(2)) || (ct_q >= mod_q);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next state; DONE waits for done to have been seen before releasing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (compute) state_d = StLoad;
      StLoad:  state_d = operand_err ? StDone : StSqr;
      StSqr:   if (mm_done) state_d = StMul;
      StMul:   if (mm_done) state_d = (idx_q == '0) ? StDone : StSqr;
      StDone:  if (!compute && done_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: multiplier control and operand select
  always_comb begin
    mm_ctrl.start = (state_q == StSqr) || (state_q == StMul);
    mm_ctrl.op    = (state_q == StMul) ? MmOpMul : MmOpSqr;
    mm_b          = (mm_ctrl.op == MmOpMul) ? ct_q : acc_q;
  end

  // Datapath next state: capture, accumulator, bit index and result
  always_comb begin
    ct_d   = ct_q;
    exp_d  = exp_q;
    mod_d  = mod_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    m_d    = m_q;
    err_d  = err_q;
    done_d = (state_q == StDone) && !(done_q && !compute);
    unique case (state_q)
      StIdle: begin
        if (compute) begin
          ct_d  = C;
          exp_d = d;
          mod_d = n;
        end
      end
      StLoad: begin
        if (operand_err) begin
          m_d   = '0;
          err_d = 1'b1;
        end else begin
          acc_d = WIDTH'(1);
          idx_d = IdxW'(WIDTH - 1);
        end
      end
      StSqr: begin
        if (mm_done) acc_d = mm_r;
      end
      StMul: begin
        if (mm_done) begin
          // The product is always computed; d[i] only decides whether it is kept
          if (exp_q[idx_q]) acc_d = mm_r;
          if (idx_q == '0) begin
            m_d   = exp_q[idx_q] ? mm_r : acc_q;
            err_d = 1'b0;
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ct_q   <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      m_q    <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ct_q   <= ct_d;
      exp_q  <= exp_d;
      mod_q  <= mod_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      m_q    <= m_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  rsa_modmul #(
    .WIDTH (WIDTH)
  ) u_modmul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mm_ctrl.start),
    .a       (acc_q),
    .b       (mm_b),
    .n       (mod_q),
    .r       (mm_r),
    .done    (mm_done)
  );

  assign M            = m_q;
  assign err          = err_q;
  assign decrypt_done = done_q;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed and randomized checks of rsa_decrypt against a right-to-left
// modular exponentiation model computed with 64-bit arithmetic.
module tb_rsa_decrypt;

  localparam int unsigned W      = 32;
  localparam int          LatOk  = 2 + 2 * W * W;
  localparam int          LatErr = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         compute = 1'b0;
  logic [W-1:0] cin = '0;
  logic [W-1:0] din = '0;
  logic [W-1:0] nin = '0;
  logic [W-1:0] m_out;
  logic         done_out;
  logic         err_out;

  int n_cmp = 0;
  int n_mis = 0;

  rsa_decrypt #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .compute      (compute),
    .C            (cin),
    .d            (din),
    .n            (nin),
    .M            (m_out),
    .decrypt_done (done_out),
    .err          (err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] c, input logic [W-1:0] e,
                                              input logic [W-1:0] m);
    longint unsigned res, base, mm;
    if (m < 2 || c >= m) return '0;
    mm   = longint'(m);
    res  = 1;
    base = longint'(c);
    for (int k = 0; k < W; k++) begin
      if (e[k]) res = (res * base) % mm;
      base = (base * base) % mm;
    end
    return res[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete transaction. scramble changes inputs after capture,
  // drop releases compute right after capture; hold keeps compute high in DONE.
  task automatic do_run(input string tag, input logic [W-1:0] c, input logic [W-1:0] e,
                        input logic [W-1:0] m, input bit scramble, input bit drop,
                        input int hold);
    logic [W-1:0] exp_m;
    logic         exp_err;
    int           exp_lat;
    int           edges;
    exp_err = (m < 2) || (c >= m);
    exp_m   = ref_modexp(c, e, m);
    exp_lat = exp_err ? LatErr : LatOk;

    @(negedge clk);
    cin = c; din = e; nin = m; compute = 1'b1;
    @(posedge clk);  // capture edge
    edges = 0;
    if (scramble || drop) begin
      @(negedge clk);
      if (scramble) begin cin = $urandom; din = $urandom; nin = $urandom; end
      if (drop) compute = 1'b0;
    end
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done_out && edges < LatOk + 10);

    check({tag, " latency"}, W'(edges), W'(exp_lat));
    check({tag, " done"}, W'(done_out), W'(1));
    check({tag, " M"}, m_out, exp_m);
    check({tag, " err"}, W'(err_out), W'(exp_err));

    if (drop) begin
      @(posedge clk); #1;
      check({tag, " done falls"}, W'(done_out), W'(0));
    end else begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check($sformatf("%s hold%0d done", tag, k), W'(done_out), W'(1));
        check($sformatf("%s hold%0d M", tag, k), m_out, exp_m);
      end
      @(negedge clk);
      compute = 1'b0;
      @(posedge clk); #1;
      check({tag, " done falls"}, W'(done_out), W'(0));
    end
    check({tag, " M retained"}, m_out, exp_m);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] rn, rc, rd;

    #12;
    check("reset M", m_out, '0);
    check("reset done", W'(done_out), W'(0));
    check("reset err", W'(err_out), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle done", W'(done_out), W'(0));

    do_run("known", 32'd16030, 32'd4909, 32'd16781, 1'b0, 1'b0, 20);
    do_run("small1", 32'd2, 32'd10, 32'd1000, 1'b0, 1'b0, 2);
    do_run("small2", 32'd100, 32'd1, 32'd323, 1'b0, 1'b0, 2);
    do_run("d0", 32'd5, 32'd0, 32'd323, 1'b0, 1'b0, 2);
    do_run("c0", 32'd0, 32'hdead_beef, 32'hffff_fffb, 1'b0, 1'b0, 2);

    do_run("err c>=n", 32'd400, 32'd7, 32'd323, 1'b0, 1'b0, 3);
    do_run("err n1", 32'd0, 32'd7, 32'd1, 1'b0, 1'b0, 3);
    do_run("err n0", 32'd0, 32'd7, 32'd0, 1'b0, 1'b0, 1);

    do_run("scramble", 32'd123457, 32'h8000_0001, 32'hfffffff1, 1'b1, 1'b0, 3);
    do_run("drop", 32'd77, 32'd65537, 32'd3233, 1'b1, 1'b1, 0);

    // Reset mid-operation clears outputs immediately
    @(negedge clk);
    cin = 32'd9; din = 32'hffff_ffff; nin = 32'd1_000_003; compute = 1'b1;
    @(posedge clk);
    repeat (1000) @(posedge clk);
    #2;
    reset_n = 1'b0;
    compute = 1'b0;
    #1;
    check("midreset M", m_out, '0);
    check("midreset done", W'(done_out), W'(0));
    check("midreset err", W'(err_out), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    do_run("after reset", 32'd9, 32'hffff_ffff, 32'd1_000_003, 1'b0, 1'b0, 1);

    for (int k = 0; k < 8; k++) begin
      rn = $urandom;
      if (rn < 2) rn = 32'd2;
      rc = $urandom % rn;
      rd = $urandom;
      do_run($sformatf("rand%0d", k), rc, rd, rn, 1'b0, 1'b0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
